// File: rtl/generation_sequencer.sv
// Walks every tile through read -> load -> run -> write-back for one Life
// generation, and fills all tiles with the preset pattern on request.
module generation_sequencer #(
  parameter int NUM_TILES = 4,
  parameter int POS_W     = 2,
  parameter int MEM_LAT   = 1,
  parameter int GEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_req,
  input  logic             preset_req,
  input  logic             enb,
  output logic [POS_W-1:0] pos,
  output logic             write_array,
  output logic             run,
  output logic             write_mem,
  output logic             wdata_sel,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count,
  output logic             overrun
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    LOAD,
    STEP,
    SETTLE,
    STORE,
    PRESET,
    DONE
  } state_t;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_TILES - 1);
  localparam logic [2:0]       LAT_LAST = 3'(MEM_LAT - 1);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       pending;
  logic       step_ok;

  assign step_ok = step_req & enb;

  // Pulse outputs are set on entry to the state they belong to, so each one
  // is high exactly during that state's cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pos         <= '0;
      wait_cnt    <= '0;
      pending     <= 1'b0;
      write_array <= 1'b0;
      run         <= 1'b0;
      write_mem   <= 1'b0;
      wdata_sel   <= 1'b0;
      busy        <= 1'b0;
      gen_done    <= 1'b0;
      gen_count   <= '0;
      overrun     <= 1'b0;
    end else begin
      write_array <= 1'b0;
      run         <= 1'b0;
      write_mem   <= 1'b0;
      gen_done    <= 1'b0;

      // One step request may queue behind the running sequence; more are lost.
      if (state != IDLE && step_ok) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (preset_req) begin
            state     <= PRESET;
            pos       <= '0;
            write_mem <= 1'b1;
            wdata_sel <= 1'b1;
            busy      <= 1'b1;
            if (step_ok) pending <= 1'b1;
          end else if (step_ok || pending) begin
            state    <= RD_WAIT;
            pos      <= '0;
            wait_cnt <= '0;
            busy     <= 1'b1;
            pending  <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == LAT_LAST) begin
            state       <= LOAD;
            write_array <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        LOAD: begin
          state <= STEP;
          run   <= 1'b1;
        end
        STEP: begin
          state <= SETTLE;
        end
        SETTLE: begin
          state     <= STORE;
          write_mem <= 1'b1;
          wdata_sel <= 1'b0;
        end
        STORE: begin
          if (pos == LAST_POS) begin
            state     <= DONE;
            gen_done  <= 1'b1;
            gen_count <= gen_count + GEN_W'(1);
            pos       <= '0;
          end else begin
            state    <= RD_WAIT;
            pos      <= pos + POS_W'(1);
            wait_cnt <= '0;
          end
        end
        PRESET: begin
          if (pos == LAST_POS) begin
            state     <= IDLE;
            busy      <= 1'b0;
            wdata_sel <= 1'b0;
            pos       <= '0;
          end else begin
            pos       <= pos + POS_W'(1);
            write_mem <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
